// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if
//   Bundles the scan controller's request, serial-detector and result signals.
//   Parameters: WIDTH (bits per word), IDXW (bit index width), CNTW (hit counter width).
//   Handshake semantics:
//     - start is a level request. It is accepted on a clock edge only while the
//       controller is idle (busy=0). While busy=1 it is ignored, not queued.
//     - ser_vld is a valid with an implicit, always-ready sink. The detector must
//       consume ser_bit on every edge where ser_vld=1. det_hit is only
//       meaningful in that same cycle.
//     - det_clr and done are single-cycle pulses with no acknowledge.
//   Modports:
//     - master: the side that owns the word and the detector (board or bench).
//     - slave:  the scan controller.
interface seq_scan_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3,
  parameter int CNTW  = 4
);
  logic [WIDTH-1:0] din;
  logic             start;
  logic             step_mode;
  logic             step;
  logic             keep;
  logic             ser_bit;
  logic             ser_vld;
  logic             det_clr;
  logic             det_hit;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  hit_cnt;
  logic [IDXW-1:0]  first_pos;
  logic             first_vld;

  modport master (
    output din, start, step_mode, step, keep, det_hit,
    input  ser_bit, ser_vld, det_clr, busy, done, hit_cnt, first_pos, first_vld
  );

  modport slave (
    input  din, start, step_mode, step, keep, det_hit,
    output ser_bit, ser_vld, det_clr, busy, done, hit_cnt, first_pos, first_vld
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Latches a parallel word and feeds it MSB first into an external Mealy
//   1011 detector. A scan runs either free (one bit per clock) or single-step
//   (one bit per rising edge of the step input). The detector is cleared
//   before the word unless keep is set at start. Hits are counted with
//   saturation, and the index of the first hit is recorded.
// Ports:
//   i_clk       : system clock, rising edge.
//   i_rst       : synchronous reset, active low.
//   bus         : seq_scan_ctrl_if.slave, which carries
//                   - request inputs: din, start, step_mode, step, keep
//                   - detector link: ser_bit, ser_vld, det_clr, det_hit
//                   - status and results: busy, done, hit_cnt, first_pos, first_vld
//   o_dbg_state : current FSM state (0 IDLE, 1 CLR, 2 SHIFT, 3 DONE).
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3,
  parameter int CNTW  = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  seq_scan_ctrl_if.slave bus,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [IDXW-1:0]  r_bitidx;
  logic [CNTW-1:0]  r_hit_cnt;
  logic [IDXW-1:0]  r_first_pos;
  logic             r_first_vld;
  logic             r_mode;
  logic             r_step_q;
  logic             r_busy;
  logic             r_done;
  logic             r_det_clr;

  logic             w_step_rise;
  logic             w_vld;
  logic             w_last;

  // ser_vld must be combinational on step. The detector consumes the bit on
  // the same edge where the controller sees the step rise.
  assign w_step_rise = bus.step & ~r_step_q;
  assign w_vld       = (r_state == S_SHIFT) && (r_mode ? w_step_rise : 1'b1);
  assign w_last      = (r_bitidx == IDXW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_bitidx    <= '0;
      r_hit_cnt   <= '0;
      r_first_pos <= '0;
      r_first_vld <= 1'b0;
      r_mode      <= 1'b0;
      // Preset high so a step input held high through reset does not count
      // as a rising edge.
      r_step_q    <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_det_clr   <= 1'b0;
    end else begin
      // Sample step in every state. Edges seen outside SHIFT are discarded.
      r_step_q <= bus.step;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shreg     <= bus.din;
            r_bitidx    <= '0;
            r_hit_cnt   <= '0;
            r_first_pos <= '0;
            r_first_vld <= 1'b0;
            r_mode      <= bus.step_mode;
            r_busy      <= 1'b1;
            r_det_clr   <= ~bus.keep;
            // keep=1 skips the clear, so a 1011 may span two words.
            r_state     <= bus.keep ? S_SHIFT : S_CLR;
          end
        end
        S_CLR: begin
          r_det_clr <= 1'b0;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_vld) begin
            r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
            r_bitidx <= r_bitidx + IDXW'(1);
            if (bus.det_hit) begin
              if (r_hit_cnt != {CNTW{1'b1}}) begin
                r_hit_cnt <= r_hit_cnt + CNTW'(1);
              end
              if (!r_first_vld) begin
                r_first_pos <= r_bitidx;
                r_first_vld <= 1'b1;
              end
            end
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The MSB is shown only in SHIFT. The shift register already holds the new
  // word during CLR, and the detector must not see it there.
  assign bus.ser_bit   = (r_state == S_SHIFT) & r_shreg[WIDTH-1];
  assign bus.ser_vld   = w_vld;
  assign bus.det_clr   = r_det_clr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.hit_cnt   = r_hit_cnt;
  assign bus.first_pos = r_first_pos;
  assign bus.first_vld = r_first_vld;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Controller that sequences the serial 1011 sequence-detection datapath.
- Latches a WIDTH-bit parallel word and feeds it one bit at a time into the external Mealy detector, MSB first. It runs either free-running (one bit per clk) or single-step (one bit per rising edge of a debounced step input).
- Clears the detector between words unless told to keep its state.
- Counts detector hits per word and records the bit position of the first hit. This lets the board display scan results instead of a single live LED.

Parameters:
- WIDTH, 8, bits per parallel word.
- IDXW, 3, width of bit index / first_pos; must satisfy 2**IDXW >= WIDTH.
- CNTW, 4, width of hit counter; saturates at 2**CNTW-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- din  input  WIDTH  parallel word; sampled only when a start is accepted.
- start  input  1  request scan of din; level, accepted only in IDLE.
- step_mode  input  1  1 = single-step, 0 = free-run; sampled with start.
- step  input  1  debounced step level; internally rising-edge detected.
- keep  input  1  1 = skip detector clear (sequence may span words); sampled with start.
- ser_bit  output  1  current serial bit to detector.
- ser_vld  output  1  detector clock-enable; bit consumed this cycle.
- det_clr  output  1  one-cycle detector clear.
- det_hit  input  1  Mealy detector output; combinational on ser_bit, valid while ser_vld=1.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse at scan end.
- hit_cnt  output  CNTW  hits in last/current scan.
- first_pos  output  IDXW  bit index (0 = MSB, first bit sent) of first hit.
- first_vld  output  1  first_pos valid.

Behaviour:
- Reset (rst=0 at edge): state IDLE; shreg, bitidx, hit_cnt, first_pos = 0; first_vld=0; step_q=1 so a step held high through reset yields no step.
- Reset outputs: ser_bit=0, ser_vld=0, det_clr=0, busy=0, done=0.
- Reset mid-scan aborts immediately; no done pulse.
- States: IDLE, CLR, SHIFT, DONE.
- IDLE: busy=0.
  - start=1 at an edge: load shreg<=din, bitidx<=0, hit_cnt<=0, first_vld<=0, first_pos<=0, and latch mode<=step_mode, kp<=keep.
  - Next state is CLR if keep=0, else SHIFT.
- CLR: det_clr=1, busy=1, ser_vld=0, for exactly one cycle; then SHIFT.
- SHIFT: busy=1; ser_bit=shreg[WIDTH-1].
  - ser_vld=1 every cycle if mode=0; if mode=1, only in cycles where step=1 and step_q=0 (step rise).
  - On a cycle with ser_vld=1: shift shreg left, bitidx++.
  - If det_hit=1 in that cycle: hit_cnt++ (saturating); if first_vld=0, set first_pos<=bitidx and first_vld<=1.
  - When bitidx=WIDTH-1 is consumed, go to DONE.
  - det_hit is ignored whenever ser_vld=0.
- DONE: done=1, busy=1, for one cycle; then IDLE. hit_cnt, first_pos and first_vld hold until the next accepted start.
- step_q<=step every cycle in all states. Step edges outside SHIFT are discarded, never queued.
- start while busy is ignored. start held high in IDLE after DONE starts a new scan (back-to-back allowed).
- Free-run latency: start sampled at edge E0 → CLR cycle → bits in the 8 cycles after it → done in the cycle after the last bit (keep=1 removes the CLR cycle).
- ser_vld and det_clr are never both 1.

Test Plan:
- Free-run, keep=0, din=8'b1011_0110 (bits 1,0,1,1,0,1,1,0) → det_clr one cycle; exactly 8 ser_vld cycles; hits at idx 3 and 6; done pulse; hit_cnt=2, first_pos=3, first_vld=1.
- din=8'h00 free-run → hit_cnt=0, first_vld=0, done after 10 cycles from start acceptance.
- Cross-word: scan 8'b0000_0101, then 8'b1000_0000 with keep=1 → second scan hit_cnt=1, first_pos=0, no det_clr. Repeat with keep=0 → hit_cnt=0.
- Single-step, din=8'b1011_1011: step held low 20 cycles → no ser_vld. Step rising edges, each held 5 cycles → one bit per rise; hit_cnt=2, first_pos=3. A step rise in IDLE is ignored.
- Saturation with CNTW=1, din=8'b1011_1011 → hit_cnt=1 (saturated).
- Abort: rst=0 asserted after 4 bits → next cycle busy=0, hit_cnt=0, no done. start during busy → ignored, shreg unchanged.
